// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder: one 4-bit lookahead group per stage, valid/ready handshake.
// Optional signed-overflow output enabled by defining CLA_PIPE_OVERFLOW_EN.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready
`ifdef CLA_PIPE_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned GROUPS = WIDTH / 4;

  // One transaction per stage: operands travel along, sum bits fill in group by group.
  typedef struct packed {
    logic             v;
    logic             c;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } stage_t;

  stage_t pipe_q [GROUPS];
  stage_t pipe_d [GROUPS];
  logic   adv;

  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  assign adv      = ~pipe_q[GROUPS-1].v | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < GROUPS; k++) begin : g_stage
    stage_t     prev;
    stage_t     nxt;
    logic [4:0] grp;

    if (k == 0) begin : g_head
      assign prev = {in_valid, cin, in1, in2, {WIDTH{1'b0}}};
    end else begin : g_body
      assign prev = pipe_q[k-1];
    end

    assign grp = cla4(prev.a[4*k +: 4], prev.b[4*k +: 4], prev.c);

    always_comb begin
      nxt              = prev;
      nxt.c            = grp[4];
      nxt.s[4*k +: 4]  = grp[3:0];
    end

    assign pipe_d[k] = nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < GROUPS; k++) pipe_q[k] <= '0;
    end else if (adv) begin
      for (int unsigned k = 0; k < GROUPS; k++) pipe_q[k] <= pipe_d[k];
    end
  end

  assign sum       = pipe_q[GROUPS-1].s;
  assign cout      = pipe_q[GROUPS-1].c;
  assign out_valid = pipe_q[GROUPS-1].v;

`ifdef CLA_PIPE_OVERFLOW_EN
  logic ovf_q;

  // Carry into the MSB is recovered as a^b^s at that bit, so no extra carry is piped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= pipe_d[GROUPS-1].a[WIDTH-1] ^ pipe_d[GROUPS-1].b[WIDTH-1]
             ^ pipe_d[GROUPS-1].s[WIDTH-1] ^ pipe_d[GROUPS-1].c;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed cases on WIDTH=16, random streams on WIDTH=4 and 64.
// Expected results come from plain-integer addition kept in per-instance queues.
module tb_pipelined_cla_adder;

  localparam int unsigned ND = 3;
  localparam int unsigned WD [ND] = '{16, 4, 64};
  localparam int unsigned NRAND = 10000;

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        o;
    int unsigned cyc;
    int unsigned st;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // staged stimulus, applied at the next falling edge
  logic [63:0] sa [ND];
  logic [63:0] sb [ND];
  logic        sv [ND];
  logic        sc [ND];
  logic        sr [ND];

  logic [63:0] a_d [ND];
  logic [63:0] b_d [ND];
  logic        v_d [ND];
  logic        c_d [ND];
  logic        r_d [ND];

  logic [63:0] sum_o  [ND];
  logic        cout_o [ND];
  logic        ov_o   [ND];
  logic        ir_o   [ND];
  logic        ovf_o  [ND];

  logic [15:0] sum16;
  logic [3:0]  sum4;
  logic [63:0] sum64;
  logic        cout16, cout4, cout64;
  logic        ov16, ov4, ov64;
  logic        ir16, ir4, ir64;

  pipelined_cla_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in1(a_d[0][15:0]), .in2(b_d[0][15:0]), .cin(c_d[0]),
    .in_valid(v_d[0]), .in_ready(ir16), .sum(sum16), .cout(cout16),
    .out_valid(ov16), .out_ready(r_d[0])
`ifdef CLA_PIPE_OVERFLOW_EN
    , .ovf(ovf_o[0])
`endif
  );

  pipelined_cla_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in1(a_d[1][3:0]), .in2(b_d[1][3:0]), .cin(c_d[1]),
    .in_valid(v_d[1]), .in_ready(ir4), .sum(sum4), .cout(cout4),
    .out_valid(ov4), .out_ready(r_d[1])
`ifdef CLA_PIPE_OVERFLOW_EN
    , .ovf(ovf_o[1])
`endif
  );

  pipelined_cla_adder #(.WIDTH(64)) u_w64 (
    .clk(clk), .rst(rst), .in1(a_d[2]), .in2(b_d[2]), .cin(c_d[2]),
    .in_valid(v_d[2]), .in_ready(ir64), .sum(sum64), .cout(cout64),
    .out_valid(ov64), .out_ready(r_d[2])
`ifdef CLA_PIPE_OVERFLOW_EN
    , .ovf(ovf_o[2])
`endif
  );

  assign sum_o[0] = {48'd0, sum16};
  assign sum_o[1] = {60'd0, sum4};
  assign sum_o[2] = sum64;
  assign cout_o[0] = cout16;
  assign cout_o[1] = cout4;
  assign cout_o[2] = cout64;
  assign ov_o[0] = ov16;
  assign ov_o[1] = ov4;
  assign ov_o[2] = ov64;
  assign ir_o[0] = ir16;
  assign ir_o[1] = ir4;
  assign ir_o[2] = ir64;
`ifndef CLA_PIPE_OVERFLOW_EN
  assign ovf_o[0] = 1'b0;
  assign ovf_o[1] = 1'b0;
  assign ovf_o[2] = 1'b0;
`endif

  exp_t        q [ND][$];
  int unsigned cyc;
  int unsigned stalls [ND];
  int unsigned n_acc  [ND];
  logic        acc    [ND];
  logic        held_v [ND];
  logic [63:0] held_s [ND];
  logic        held_c [ND];
  logic        held_o [ND];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] wmask(input int unsigned w);
    return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  task automatic set_in(input int unsigned d, input logic v, input logic [63:0] a,
                        input logic [63:0] b, input logic c, input logic r);
    sv[d] = v; sa[d] = a; sb[d] = b; sc[d] = c; sr[d] = r;
  endtask

  task automatic set_idle();
    for (int unsigned d = 0; d < ND; d++) set_in(d, 1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  task automatic tick();
    exp_t        e;
    int unsigned w;
    logic [63:0] am, bm;
    logic [64:0] full;
    @(negedge clk);
    rst = 1'b0;
    for (int unsigned d = 0; d < ND; d++) begin
      v_d[d] = sv[d]; a_d[d] = sa[d]; b_d[d] = sb[d]; c_d[d] = sc[d]; r_d[d] = sr[d];
    end
    #1;
    cyc++;
    for (int unsigned d = 0; d < ND; d++) begin
      w = WD[d];
      acc[d] = 1'b0;
      if (held_v[d]) begin
        check($sformatf("hold_valid_w%0d", w), {63'd0, ov_o[d]}, 64'd1);
        check($sformatf("hold_sum_w%0d", w), sum_o[d], held_s[d]);
        check($sformatf("hold_cout_w%0d", w), {63'd0, cout_o[d]}, {63'd0, held_c[d]});
`ifdef CLA_PIPE_OVERFLOW_EN
        check($sformatf("hold_ovf_w%0d", w), {63'd0, ovf_o[d]}, {63'd0, held_o[d]});
`endif
      end
      if (!ov_o[d]) check($sformatf("ready_idle_w%0d", w), {63'd0, ir_o[d]}, 64'd1);
      if (ov_o[d] && r_d[d]) begin
        if (q[d].size() == 0) begin
          check($sformatf("spurious_w%0d", w), 64'd1, 64'd0);
        end else begin
          e = q[d].pop_front();
          check($sformatf("sum_w%0d", w), sum_o[d], e.s);
          check($sformatf("cout_w%0d", w), {63'd0, cout_o[d]}, {63'd0, e.c});
`ifdef CLA_PIPE_OVERFLOW_EN
          check($sformatf("ovf_w%0d", w), {63'd0, ovf_o[d]}, {63'd0, e.o});
`endif
          if (stalls[d] == e.st)
            check($sformatf("latency_w%0d", w), 64'(cyc - e.cyc), 64'(w / 4));
        end
      end
      held_v[d] = ov_o[d] && !r_d[d];
      if (held_v[d]) begin
        check($sformatf("stall_ready_w%0d", w), {63'd0, ir_o[d]}, 64'd0);
        stalls[d]++;
        held_s[d] = sum_o[d];
        held_c[d] = cout_o[d];
        held_o[d] = ovf_o[d];
      end
      if (v_d[d] && ir_o[d]) begin
        am     = a_d[d] & wmask(w);
        bm     = b_d[d] & wmask(w);
        full   = {1'b0, am} + {1'b0, bm} + {64'd0, c_d[d]};
        e.s    = full[63:0] & wmask(w);
        e.c    = full[w];
        e.o    = (am[w-1] == bm[w-1]) && (e.s[w-1] != am[w-1]);
        e.cyc  = cyc;
        e.st   = stalls[d];
        q[d].push_back(e);
        acc[d] = 1'b1;
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    set_idle();
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  // Reset is held across exactly one rising edge; the next tick releases it.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int unsigned d = 0; d < ND; d++) begin
      v_d[d] = 1'b0; r_d[d] = 1'b1;
    end
    #1;
    for (int unsigned d = 0; d < ND; d++) begin
      check($sformatf("rst_valid_w%0d", WD[d]), {63'd0, ov_o[d]}, 64'd0);
      check($sformatf("rst_sum_w%0d", WD[d]), sum_o[d], 64'd0);
      check($sformatf("rst_cout_w%0d", WD[d]), {63'd0, cout_o[d]}, 64'd0);
      check($sformatf("rst_ready_w%0d", WD[d]), {63'd0, ir_o[d]}, 64'd1);
`ifdef CLA_PIPE_OVERFLOW_EN
      check($sformatf("rst_ovf_w%0d", WD[d]), {63'd0, ovf_o[d]}, 64'd0);
`endif
      q[d].delete();
      held_v[d] = 1'b0;
    end
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic c);
    set_idle();
    set_in(0, 1'b1, {48'd0, a}, {48'd0, b}, c, 1'b1);
    tick();
    check("accept16", {63'd0, acc[0]}, 64'd1);
    set_idle();
  endtask

  initial begin
    int unsigned t;
    int unsigned i;
    int unsigned guard;
    cyc = 0;
    for (int unsigned d = 0; d < ND; d++) begin
      stalls[d] = 0; n_acc[d] = 0; held_v[d] = 1'b0; acc[d] = 1'b0;
      v_d[d] = 1'b0; a_d[d] = '0; b_d[d] = '0; c_d[d] = 1'b0; r_d[d] = 1'b1;
    end
    set_idle();
    do_reset();

    send16(16'h1234, 16'h4321, 1'b0);
    idle(6);
    send16(16'hFFFF, 16'h0000, 1'b1);
    idle(6);
    send16(16'h7FFF, 16'h0001, 1'b0);
    idle(6);
    send16(16'h8000, 16'h8000, 1'b0);
    idle(6);

    // 8 back-to-back sets with the consumer stalled for 3 cycles mid-stream
    t = 0; i = 0;
    while (i < 8 && t < 40) begin
      set_idle();
      set_in(0, 1'b1, {48'd0, 16'($urandom)}, {48'd0, 16'($urandom)}, 1'($urandom_range(0, 1)),
             !(t >= 5 && t <= 7));
      tick();
      if (acc[0]) i++;
      t++;
    end
    check("stream_accepted", 64'(i), 64'd8);
    idle(8);
    check("stream_drained", 64'(q[0].size()), 64'd0);

    // reset with three sets in flight, then a fresh set right after release
    for (int unsigned k = 0; k < 3; k++) begin
      set_idle();
      set_in(0, 1'b1, {48'd0, 16'($urandom)}, {48'd0, 16'($urandom)}, 1'b0, 1'b1);
      tick();
    end
    do_reset();
    send16(16'hABCD, 16'h1111, 1'b1);
    idle(8);
    check("post_reset_drained", 64'(q[0].size()), 64'd0);

    // random streams on WIDTH=4 and WIDTH=64
    guard = 0;
    while ((n_acc[1] < NRAND || n_acc[2] < NRAND) && guard < 60000) begin
      set_idle();
      for (int unsigned d = 1; d < ND; d++) begin
        set_in(d, (n_acc[d] < NRAND) && ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 7) == 0) ? '1 : {$urandom, $urandom},
               ($urandom_range(0, 7) == 0) ? '0 : {$urandom, $urandom},
               1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      end
      tick();
      for (int unsigned d = 1; d < ND; d++) if (acc[d]) n_acc[d]++;
      guard++;
    end
    check("rand_count_w4", 64'(n_acc[1]), 64'(NRAND));
    check("rand_count_w64", 64'(n_acc[2]), 64'(NRAND));
    idle(40);
    for (int unsigned d = 0; d < ND; d++)
      check($sformatf("final_drained_w%0d", WD[d]), 64'(q[d].size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
